serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_pkg.sv | 17 +
 rtl/ha_cell.sv | 20 ++
 rtl/serial_add_ctrl.sv | 124 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// ---------------------------------------------------------------------------
// serial_add_pkg
// Shared definitions for the bit-serial adder controller:
//   - state_t       : FSM state encoding (IDLE, RUN, DONE)
//   - DEFAULT_WIDTH : default operand width used by serial_add_ctrl
// ---------------------------------------------------------------------------
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : serial_add_pkg

// File: rtl/ha_cell.sv
// ---------------------------------------------------------------------------
// ha_cell
// Combinational half adder. Two of these plus an OR make one full-adder
// bit slice.
// Ports:
//   x, y : input bits
//   s    : sum   (x ^ y)
//   c    : carry (x & y)
// ---------------------------------------------------------------------------
module ha_cell (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = x ^ y;
    assign c = x & y;

endmodule : ha_cell

// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial adder: adds two WIDTH-bit operands one bit per clock, LSB first,
// using a single full-adder slice built from two half-adder cells.
// Ports:
//   CLK    : clock, rising edge
//   reset  : synchronous, active-high reset
//   start  : request an addition (only looked at in IDLE)
//   a, b   : operands, captured when start is accepted
//   busy   : high whenever the FSM is not in IDLE
//   done   : one-cycle pulse when result/cout are updated
//   result : (a + b) mod 2^WIDTH, held until the next completion or reset
//   cout   : carry out of bit WIDTH-1, held like result
// Timing: the accepting edge is followed by WIDTH RUN cycles and then one
// DONE cycle, so busy is high for WIDTH+1 cycles per addition.
// ---------------------------------------------------------------------------
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, r_sr;
    logic [WIDTH-1:0] r_shift;
    logic             c;
    logic [CW-1:0]    cnt;
    logic             last_bit;

    // Full-adder slice: sum = a^b^c, carry = majority(a, b, c)
    logic p, g0, g1, sum, c_next;

    ha_cell u_ha0 (
        .x (a_sr[0]),
        .y (b_sr[0]),
        .s (p),
        .c (g0)
    );

    ha_cell u_ha1 (
        .x (p),
        .y (c),
        .s (sum),
        .c (g1)
    );

    assign c_next   = g0 | g1;
    assign r_shift  = {sum, r_sr[WIDTH-1:1]};
    assign last_bit = (cnt == CW'(WIDTH - 1));

    // Next-state logic
    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned; otherwise a latch would be inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, datapath and output registers. busy and done are registered
    // from state_nxt so every output comes straight from a flop.
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            a_sr   <= '0;
            b_sr   <= '0;
            r_sr   <= '0;
            c      <= 1'b0;
            cnt    <= '0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            done  <= (state_nxt == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr <= a;
                        b_sr <= b;
                        c    <= 1'b0;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    r_sr <= r_shift;
                    c    <= c_next;
                    // Counter stops at WIDTH-1 instead of wrapping.
                    if (!last_bit) begin
                        cnt <= cnt + CW'(1);
                    end else begin
                        // Final bit: publish the completed sum and carry.
                        result <= r_shift;
                        cout   <= c_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_add_ctrl
// Self-checking bench for serial_add_ctrl (WIDTH = 8). Directed vectors come
// from a table, random vectors are checked against plain a+b arithmetic, and
// hand-written sequences cover held start, late operand changes and reset
// aborting a run.
// ---------------------------------------------------------------------------
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         CLK;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;

    int n_cmp = 0;
    int n_err = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .CLK    (CLK),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [W-1:0] er;
        logic         ec;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One complete addition starting from IDLE. If change_at > 0, a and b
    // are overwritten with new_val during that RUN cycle.
    task automatic run_add(input logic [W-1:0] va, input logic [W-1:0] vb,
                           input logic [W-1:0] er, input logic ec,
                           input string tag, input int change_at,
                           input logic [W-1:0] new_val);
        int lat;
        int busy_cnt;
        int moved;
        logic [W-1:0] prev_r;
        logic prev_c;
        prev_r = result;
        prev_c = cout;
        a = va;
        b = vb;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        busy_cnt = int'(busy);
        moved = 0;
        while (!done && lat < 40) begin
            if (result !== prev_r || cout !== prev_c) moved++;
            if (lat == change_at) begin
                a = new_val;
                b = new_val;
            end
            tick();
            lat++;
            busy_cnt += int'(busy);
        end
        check({tag, " done_seen"}, 32'(done), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(W + 1));
        check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(W + 1));
        check({tag, " result"}, 32'(result), 32'(er));
        check({tag, " cout"}, 32'(cout), 32'(ec));
        check({tag, " outputs_held_in_run"}, 32'(moved), 32'd0);
        tick();
        check({tag, " done_one_cycle"}, 32'(done), 32'd0);
        check({tag, " idle_after_done"}, 32'(busy), 32'd0);
        check({tag, " result_held"}, 32'(result), 32'(er));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W:0] model;
        logic [W-1:0] ra, rb;
        int first_done, prev_done, n_done, done_seen;

        vecs[0] = '{8'h5A, 8'h33, 8'h8D, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[2] = '{8'h00, 8'h00, 8'h00, 1'b0};
        vecs[3] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
        vecs[4] = '{8'h7F, 8'h01, 8'h80, 1'b0};
        vecs[5] = '{8'hAA, 8'h55, 8'hFF, 1'b0};
        vecs[6] = '{8'hC3, 8'h5E, 8'h21, 1'b1};

        reset = 1'b1;
        start = 1'b1;
        a = 8'hFF;
        b = 8'hFF;
        tick();
        tick();
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", 32'(result), 32'd0);
        check("reset cout", 32'(cout), 32'd0);
        reset = 1'b0;
        start = 1'b0;

        // Table-driven directed vectors; the first start follows reset directly.
        for (int i = 0; i < 7; i++) begin
            run_add(vecs[i].va, vecs[i].vb, vecs[i].er, vecs[i].ec,
                    $sformatf("vec%0d", i), 0, 8'h00);
        end

        // Operands overwritten to 0xFF in RUN cycle 3 must not matter.
        run_add(8'h01, 8'h02, 8'h03, 1'b0, "late_change", 3, 8'hFF);

        // Random operands against plain arithmetic, with operands scrambled
        // at a random point after acceptance.
        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            model = {1'b0, ra} + {1'b0, rb};
            run_add(ra, rb, model[W-1:0], model[W], $sformatf("rnd%0d", i),
                    int'($urandom_range(1, W)), W'($urandom));
        end

        // Start held high: accepted only from IDLE, one done every W+2 cycles.
        a = 8'h10;
        b = 8'h20;
        start = 1'b1;
        first_done = -1;
        prev_done = -1;
        n_done = 0;
        for (int cyc = 1; cyc <= 4 * (W + 2); cyc++) begin
            tick();
            if (done) begin
                n_done++;
                check("held result", 32'(result), 32'h30);
                check("held cout", 32'(cout), 32'd0);
                if (first_done < 0) first_done = cyc;
                else check("held period", 32'(cyc - prev_done), 32'(W + 2));
                prev_done = cyc;
            end
        end
        start = 1'b0;
        check("held first_done", 32'(first_done), 32'(W + 1));
        check("held done_count", 32'(n_done), 32'd4);
        for (int i = 0; i < W + 3 && busy; i++) tick();
        check("held back_to_idle", 32'(busy), 32'd0);

        // Reset in RUN cycle 4 aborts the addition without a done pulse.
        run_add(8'h01, 8'h02, 8'h03, 1'b0, "pre_abort", 0, 8'h00);
        a = 8'h11;
        b = 8'h22;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("abort in_run", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort result", 32'(result), 32'd0);
        check("abort cout", 32'(cout), 32'd0);
        done_seen = 0;
        for (int i = 0; i < W + 4; i++) begin
            tick();
            done_seen += int'(done);
        end
        check("abort no_done", 32'(done_seen), 32'd0);
        run_add(8'h80, 8'h80, 8'h00, 1'b1, "post_abort", 0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_serial_add_ctrl
